// File: rtl/dcache_mshr_ctrl.sv
// dcache_mshr_ctrl: non-blocking dcache miss controller with tagged bus loads,
// store-merged fills, sized load return and a one-entry write-through evict buffer.
module dcache_mshr_ctrl #(
    parameter int NUM_MSHR  = 4,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 64,
    parameter int MEM_TAG_W = 4,
    parameter int LSQ_ID_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic                 miss_is_store,
    input  logic [2:0]           miss_size,
    input  logic [31:0]          miss_wdata,
    input  logic [LSQ_ID_W-1:0]  miss_lsq_id,
    input  logic                 evict_valid,
    output logic                 evict_ready,
    input  logic [ADDR_W-1:0]    evict_addr,
    input  logic [LINE_W-1:0]    evict_data,
    output logic [1:0]           mem_cmd,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_W-1:0]    mem_wdata,
    input  logic [MEM_TAG_W-1:0] mem_response,
    input  logic [MEM_TAG_W-1:0] mem_tag,
    input  logic [LINE_W-1:0]    mem_rdata,
    output logic                 fill_valid,
    output logic [ADDR_W-1:0]    fill_addr,
    output logic [LINE_W-1:0]    fill_data,
    output logic                 done_valid,
    output logic [LSQ_ID_W-1:0]  done_lsq_id,
    output logic                 done_is_store,
    output logic [31:0]          done_data,
    output logic [NUM_MSHR-1:0]  mshr_busy
);
    localparam int NB = LINE_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int AGE_W = $clog2(NUM_MSHR);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(NB - 1);
    localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;

    typedef enum logic [1:0] {FREE, PEND, ISSUED} state_t;

    state_t               st     [NUM_MSHR];
    state_t               st_nxt [NUM_MSHR];
    logic [ADDR_W-1:0]    e_addr [NUM_MSHR];
    logic                 e_store[NUM_MSHR];
    logic [2:0]           e_size [NUM_MSHR];
    logic [31:0]          e_wdata[NUM_MSHR];
    logic [LSQ_ID_W-1:0]  e_lsq  [NUM_MSHR];
    logic [MEM_TAG_W-1:0] e_tag  [NUM_MSHR];
    logic [AGE_W-1:0]     e_age  [NUM_MSHR];
    logic                 ev_full;
    logic [ADDR_W-1:0]    ev_addr;
    logic [LINE_W-1:0]    ev_data;

    logic [NUM_MSHR-1:0] alloc_oh, issue_oh, hit_oh;
    logic                same_line, accept, issue_ok;
    logic [AGE_W-1:0]    best_age, h_age;
    logic [ADDR_W-1:0]   i_addr, h_addr;
    logic                h_store;
    logic [2:0]          h_size;
    logic [31:0]         h_wdata, lw, ld;
    logic [LSQ_ID_W-1:0] h_lsq;
    logic [OFF_W-1:0]    off;
    logic [NB-1:0]       bmask;
    logic [LINE_W-1:0]   wmask, wline;

    always_comb begin
        alloc_oh = '0;
        issue_oh = '0;
        hit_oh = '0;
        same_line = 1'b0;
        best_age = '0;
        i_addr = '0;
        h_age = '0;
        h_addr = '0;
        h_store = 1'b0;
        h_size = '0;
        h_wdata = '0;
        h_lsq = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--)
            if (st[i] == FREE) alloc_oh = NUM_MSHR'(1) << i;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (st[i] != FREE && ((e_addr[i] ^ miss_addr) & LINE_MASK) == '0) same_line = 1'b1;
            // largest age among pending entries is the oldest allocation
            if (st[i] == PEND && (issue_oh == '0 || e_age[i] > best_age)) begin
                issue_oh = NUM_MSHR'(1) << i;
                best_age = e_age[i];
                i_addr = e_addr[i];
            end
            if (st[i] == ISSUED && mem_tag != '0 && e_tag[i] == mem_tag) begin
                hit_oh = NUM_MSHR'(1) << i;
                h_age = e_age[i];
                h_addr = e_addr[i];
                h_store = e_store[i];
                h_size = e_size[i];
                h_wdata = e_wdata[i];
                h_lsq = e_lsq[i];
            end
        end
    end

    assign miss_ready = |alloc_oh && !same_line;
    assign accept = miss_valid && miss_ready;
    assign issue_ok = !ev_full && mem_response != '0;
    assign evict_ready = !ev_full;

    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            st_nxt[i] = st[i];
            if (accept && alloc_oh[i]) st_nxt[i] = PEND;
            if (issue_oh[i] && issue_ok) st_nxt[i] = ISSUED;
            if (hit_oh[i]) st_nxt[i] = FREE;
            mshr_busy[i] = st[i] != FREE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                st[i] <= FREE;
                e_addr[i] <= '0;
                e_store[i] <= 1'b0;
                e_size[i] <= '0;
                e_wdata[i] <= '0;
                e_lsq[i] <= '0;
                e_tag[i] <= '0;
                e_age[i] <= '0;
            end
            ev_full <= 1'b0;
            ev_addr <= '0;
            ev_data <= '0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                st[i] <= st_nxt[i];
                if (accept && alloc_oh[i]) begin
                    e_addr[i] <= miss_addr;
                    e_store[i] <= miss_is_store;
                    e_size[i] <= miss_size;
                    e_wdata[i] <= miss_wdata;
                    e_lsq[i] <= miss_lsq_id;
                    e_age[i] <= '0;
                end else if (st[i] != FREE)
                    // age counts younger live entries, so it stays below NUM_MSHR
                    e_age[i] <= e_age[i] + AGE_W'(accept) - AGE_W'(|hit_oh && e_age[i] > h_age);
                if (issue_oh[i] && issue_ok) e_tag[i] <= mem_response;
            end
            if (ev_full) ev_full <= mem_response == '0;
            else if (evict_valid) begin
                ev_full <= 1'b1;
                ev_addr <= evict_addr;
                ev_data <= evict_data;
            end
        end
    end

    assign mem_cmd = ev_full ? BUS_STORE : |issue_oh ? BUS_LOAD : BUS_NONE;
    assign mem_addr = (ev_full ? ev_addr : i_addr) & LINE_MASK;
    assign mem_wdata = ev_full ? ev_data : '0;

    always_comb begin
        off = h_addr[OFF_W-1:0];
        bmask = NB'(h_size[1] ? 4'hF : h_size[0] ? 4'h3 : 4'h1) << off;
        for (int b = 0; b < NB; b++) wmask[8*b +: 8] = {8{bmask[b]}};
        wline = LINE_W'(h_wdata) << {off, 3'b000};
        lw = 32'(mem_rdata >> {off, 3'b000});
        ld = h_size[1] ? lw : h_size[0] ? {{16{lw[15] & ~h_size[2]}}, lw[15:0]}
                                        : {{24{lw[7] & ~h_size[2]}}, lw[7:0]};
    end

    assign fill_valid = |hit_oh;
    assign done_valid = fill_valid;
    assign fill_addr = h_addr & LINE_MASK;
    assign fill_data = !fill_valid ? '0 : h_store ? (mem_rdata & ~wmask) | (wline & wmask) : mem_rdata;
    assign done_lsq_id = h_lsq;
    assign done_is_store = h_store;
    assign done_data = fill_valid && !h_store ? ld : '0;
endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// tb_dcache_mshr_ctrl: vector table of single misses plus hand sequences for
// full/out-of-order, same-line stall, evict priority and reset; fills go through a scoreboard.
module tb_dcache_mshr_ctrl;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        miss_valid, miss_ready, miss_is_store, evict_valid, evict_ready;
    logic [31:0] miss_addr, miss_wdata, evict_addr, mem_addr, fill_addr, done_data;
    logic [2:0]  miss_size;
    logic [3:0]  miss_lsq_id, mem_response, mem_tag, done_lsq_id, mshr_busy;
    logic [63:0] evict_data, mem_wdata, mem_rdata, fill_data;
    logic [1:0]  mem_cmd;
    logic        fill_valid, done_valid, done_is_store;

    always #5 clock = ~clock;

    dcache_mshr_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_is_store(miss_is_store), .miss_size(miss_size), .miss_wdata(miss_wdata),
        .miss_lsq_id(miss_lsq_id), .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_addr(evict_addr), .evict_data(evict_data), .mem_cmd(mem_cmd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_response(mem_response),
        .mem_tag(mem_tag), .mem_rdata(mem_rdata), .fill_valid(fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data), .done_valid(done_valid),
        .done_lsq_id(done_lsq_id), .done_is_store(done_is_store), .done_data(done_data),
        .mshr_busy(mshr_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] fill;
        logic [3:0]  lsq;
        logic        st;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        st;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  lsq;
        logic [3:0]  tag;
        logic [63:0] rdata;
        logic [63:0] fill;
        logic [31:0] done;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (!reset_n || !(fill_valid || done_valid)) return;
        if (sb.size() == 0) chk("unexpected_fill", {fill_valid, done_valid}, 0);
        else begin
            e = sb.pop_front();
            chk("fill_valid", fill_valid, 1);
            chk("done_valid", done_valid, 1);
            chk("fill_addr", fill_addr, e.addr);
            chk("fill_data", fill_data, e.fill);
            chk("done_lsq_id", done_lsq_id, e.lsq);
            chk("done_is_store", done_is_store, e.st);
            chk("done_data", done_data, e.data);
        end
    endtask

    task automatic half_n();
        @(negedge clock);
        monitor();
    endtask

    task automatic half_p();
        @(posedge clock);
        #1;
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic set_miss(input logic [31:0] a, input logic s, input logic [2:0] sz,
                            input logic [31:0] wd, input logic [3:0] id);
        miss_valid = 1'b1;
        miss_addr = a;
        miss_is_store = s;
        miss_size = sz;
        miss_wdata = wd;
        miss_lsq_id = id;
    endtask

    task automatic ret(input logic [3:0] t, input logic [63:0] rd, input exp_t e);
        mem_tag = t;
        mem_rdata = rd;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        set_miss(v.addr, v.st, v.size, v.wdata, v.lsq);
        half_n();
        chk("vec_ready", miss_ready, 1);
        half_p();
        miss_valid = 1'b0;
        half_n();
        chk("vec_cmd", mem_cmd, 2'd1);
        chk("vec_addr", mem_addr, v.addr & 32'hFFFF_FFF8);
        mem_response = v.tag;
        half_p();
        mem_response = 0;
        half_n();
        chk("vec_cmd_idle", mem_cmd, 2'd0);
        half_p();
        ret(v.tag, v.rdata, '{v.addr & 32'hFFFF_FFF8, v.fill, v.lsq, v.st, v.done});
        half_n();
        drained("vec_fill_seen");
        half_p();
        mem_tag = 0;
        half_n();
        chk("vec_busy_after", mshr_busy, 0);
        half_p();
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic [3:0] t;
        logic [3:0] ord[4];
        vt[0] = '{32'h104, 0, 3'd2, 32'h0, 4'd1, 4'd3, 64'h1122334455667788, 64'h1122334455667788, 32'h11223344};
        vt[1] = '{32'h101, 1, 3'd0, 32'hDEADBEAB, 4'd2, 4'd1, 64'h1122334455667788, 64'h112233445566AB88, 32'h0};
        vt[2] = '{32'h200, 0, 3'd4, 32'h0, 4'd3, 4'd2, 64'h0123456789ABCD80, 64'h0123456789ABCD80, 32'h00000080};
        vt[3] = '{32'h200, 0, 3'd0, 32'h0, 4'd4, 4'd4, 64'h0123456789ABCD80, 64'h0123456789ABCD80, 32'hFFFFFF80};
        vt[4] = '{32'h306, 0, 3'd1, 32'h0, 4'd5, 4'd5, 64'h8001000000000000, 64'h8001000000000000, 32'hFFFF8001};
        vt[5] = '{32'h306, 0, 3'd5, 32'h0, 4'd6, 4'd6, 64'h8001000000000000, 64'h8001000000000000, 32'h00008001};
        vt[6] = '{32'h402, 1, 3'd1, 32'h1234BEEF, 4'd7, 4'd7, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFBEEFFFFF, 32'h0};
        vt[7] = '{32'h504, 1, 3'd2, 32'hCAFEF00D, 4'd8, 4'd15, 64'h0, 64'hCAFEF00D00000000, 32'h0};
        vt[8] = '{32'h607, 0, 3'd0, 32'h0, 4'd9, 4'd9, 64'h7F00000000000000, 64'h7F00000000000000, 32'h0000007F};
        ord = '{4'd4, 4'd2, 4'd1, 4'd3};
        miss_valid = 0; miss_addr = 0; miss_is_store = 0; miss_size = 0; miss_wdata = 0; miss_lsq_id = 0;
        evict_valid = 0; evict_addr = 0; evict_data = 0; mem_response = 0; mem_tag = 0; mem_rdata = 0;

        #12;
        chk("rst_cmd", mem_cmd, 0);
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_evict_ready", evict_ready, 1);
        chk("rst_busy", mshr_busy, 0);
        chk("rst_fill", {fill_valid, done_valid}, 0);
        chk("rst_data", {done_data, fill_data[31:0]}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        half_p();

        foreach (vt[i]) run_vec(vt[i]);

        // all four entries busy, bus refuses three cycles, then tags 1..4 in age order
        for (int k = 0; k < 4; k++) begin
            set_miss(32'((k + 1) << 12), 0, 3'd2, 0, 4'(k + 1));
            half_n();
            chk("fill4_ready", miss_ready, 1);
            half_p();
        end
        miss_valid = 0;
        miss_addr = 32'h5000;
        for (int k = 0; k < 3; k++) begin
            half_n();
            chk("full_ready", miss_ready, 0);
            chk("full_busy", mshr_busy, 4'hF);
            chk("retry_cmd", mem_cmd, 2'd1);
            chk("retry_addr", mem_addr, 32'h1000);
            half_p();
        end
        for (int k = 0; k < 4; k++) begin
            half_n();
            chk("age_cmd", mem_cmd, 2'd1);
            chk("age_addr", mem_addr, 32'((k + 1) << 12));
            mem_response = 4'(k + 1);
            half_p();
            mem_response = 0;
        end
        half_n();
        chk("issued_idle", mem_cmd, 0);
        half_p();
        for (int j = 0; j < 4; j++) begin
            t = ord[j];
            rd = {28'h0, t, 32'hC0DE_0000 | 32'(t)};
            ret(t, rd, '{32'(t) << 12, rd, t, 0, 32'hC0DE_0000 | 32'(t)});
            half_n();
            drained("ooo_fill_seen");
            if (j == 0) chk("ready_same_cycle", miss_ready, 0);
            half_p();
            mem_tag = 0;
            if (j == 0) begin
                half_n();
                chk("ready_next_cycle", miss_ready, 1);
                half_p();
            end
        end
        half_n();
        chk("ooo_busy_after", mshr_busy, 0);
        half_p();

        // same-line stall, then evict and pending load in the same cycle
        set_miss(32'h700, 0, 3'd2, 0, 4'd5);
        half_n();
        half_p();
        set_miss(32'h703, 1, 3'd0, 32'hFFFFFF5A, 4'd6);
        half_n();
        chk("same_line_pend", miss_ready, 0);
        mem_response = 5;
        half_p();
        mem_response = 0;
        half_n();
        chk("same_line_issued", miss_ready, 0);
        half_p();
        ret(5, 64'h0102030405060708, '{32'h700, 64'h0102030405060708, 4'd5, 0, 32'h05060708});
        half_n();
        drained("sl_fill_seen");
        chk("same_line_fill_cycle", miss_ready, 0);
        half_p();
        mem_tag = 0;
        evict_valid = 1;
        evict_addr = 32'h905;
        evict_data = 64'hFEEDFACE0BADF00D;
        half_n();
        chk("same_line_released", miss_ready, 1);
        chk("evict_ready_empty", evict_ready, 1);
        half_p();
        miss_valid = 0;
        evict_valid = 0;
        for (int k = 0; k < 2; k++) begin
            half_n();
            chk("evict_cmd", mem_cmd, 2'd2);
            chk("evict_addr", mem_addr, 32'h900);
            chk("evict_wdata", mem_wdata, 64'hFEEDFACE0BADF00D);
            chk("evict_ready_full", evict_ready, 0);
            mem_response = k == 1 ? 4'd7 : 4'd0;
            half_p();
        end
        mem_response = 0;
        half_n();
        chk("after_evict_cmd", mem_cmd, 2'd1);
        chk("after_evict_addr", mem_addr, 32'h700);
        chk("after_evict_ready", evict_ready, 1);
        mem_response = 6;
        half_p();
        mem_response = 0;
        ret(6, 64'h0102030405060708, '{32'h700, 64'h010203045A060708, 4'd6, 1, 32'h0});
        half_n();
        drained("st_fill_seen");
        half_p();
        mem_tag = 0;

        // reset with two issued entries, then their tags come back
        set_miss(32'hA00, 0, 3'd2, 0, 4'd7);
        half_n();
        half_p();
        set_miss(32'hB00, 0, 3'd2, 0, 4'd8);
        half_n();
        mem_response = 8;
        half_p();
        miss_valid = 0;
        mem_response = 0;
        half_n();
        chk("rst2_cmd_b", mem_addr, 32'hB00);
        mem_response = 9;
        half_p();
        mem_response = 0;
        half_n();
        chk("rst2_busy_before", mshr_busy, 4'h3);
        #2;
        reset_n = 0;
        #1;
        chk("rst2_busy_async", mshr_busy, 0);
        chk("rst2_ready_async", miss_ready, 1);
        half_n();
        reset_n = 1;
        half_p();
        mem_tag = 8;
        mem_rdata = 64'h1234;
        half_n();
        chk("stale_tag8", {fill_valid, done_valid}, 0);
        half_p();
        mem_tag = 9;
        half_n();
        chk("stale_tag9", {fill_valid, done_valid}, 0);
        half_p();
        mem_tag = 0;
        drained("sb_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
